multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: instruction sequencing, datapath selects, NZCV flags and
// condition gating. Defining CTRL_PERFCNT_EN adds the InstrCount fetch counter port.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
`ifdef CTRL_PERFCNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, IDLE_BAD
  } state_t;

  state_t     state;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  logic [3:0] flags;
  logic       condex;
  logic       condexq;
  logic [1:0] dp_alu;
  logic       dp_flagwr;
  logic       dp_cvwr;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, res;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cy;
      4'b0011: res = ~cy;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cy & ~z;
      4'b1001: res = ~cy | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign condex = cond_eval(cond, flags);

  // Unsupported commands execute as ADD but never touch the flags.
  always_comb begin
    dp_alu    = 2'b00;
    dp_flagwr = 1'b0;
    dp_cvwr   = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_alu = 2'b00; dp_flagwr = 1'b1; dp_cvwr = 1'b1; end
      4'b0010: begin dp_alu = 2'b01; dp_flagwr = 1'b1; dp_cvwr = 1'b1; end
      4'b0000: begin dp_alu = 2'b10; dp_flagwr = 1'b1; end
      4'b1100: begin dp_alu = 2'b11; dp_flagwr = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= 4'b0000;
      condexq <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          condexq <= condex;
          case (op)
            2'b00:   state <= funct[5] ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= IDLE_BAD;
          endcase
        end
        MEMADR: state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR, EXECI: begin
          state <= ALUWB;
          if (funct[0] && condexq && dp_flagwr) begin
            flags[3:2] <= ALUFlags[3:2];
            if (dp_cvwr)
              flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condexq;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condexq;
      end
      EXECR: ALUControl = dp_alu;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      ALUWB: begin
        RegWrite = condexq;
        PCWrite  = condexq & (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condexq;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

`ifdef CTRL_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      InstrCount <= 32'd0;
    else if (state == FETCH)
      InstrCount <= InstrCount + 32'd1;
  end
`endif

endmodule
